// File: rtl/program_counter_stack.sv
// program_counter_stack: PC with count/jump, CALL/RET return stack and stack error
// reporting. Define PC_ERR_STICKY_EN to make err/err_code latch until err_clr.
module program_counter_stack #(
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       count_en,
    input  logic                       jump,
    input  logic                       call,
    input  logic                       ret,
    input  logic [ADDR_W-1:0]          jump_addr,
    input  logic                       err_clr,
    output logic [ADDR_W-1:0]          addr,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       wrap,
    output logic                       err,
    output logic [1:0]                 err_code
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int SLOTS = 2 ** SP_W;
    localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADDR);
    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_OVF  = 2'b01;
    localparam logic [1:0] E_UNF  = 2'b10;

    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d, ev_code;
    logic [ADDR_W-1:0] stack_q [SLOTS];
    logic [ADDR_W-1:0] stack_d [SLOTS];
    logic              full, empty;

    assign addr_inc = addr_q + ADDR_W'(1);
    assign full     = sp_q == SP_W'(DEPTH);
    assign empty    = sp_q == '0;

    // One operation per edge, priority ret > call > jump > count_en > hold.
    always_comb begin
        addr_d  = addr_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        wrap_d  = 1'b0;
        ev_code = E_NONE;
        if (ret) begin
            if (empty) begin
                ev_code = E_UNF;
            end else begin
                addr_d = stack_q[sp_q - SP_W'(1)];
                sp_d   = sp_q - SP_W'(1);
            end
        end else if (call) begin
            if (full) begin
                ev_code = E_OVF;
            end else begin
                stack_d[sp_q] = addr_inc;
                sp_d          = sp_q + SP_W'(1);
                addr_d        = jump_addr;
            end
        end else if (jump) begin
            addr_d = jump_addr;
        end else if (count_en) begin
            addr_d = addr_inc;
            wrap_d = &addr_q;
        end
    end

`ifdef PC_ERR_STICKY_EN
    // Hold the first error until cleared; a clear in the same cycle as a new error shows the new one.
    always_comb begin
        err_code_d = (err_q && !err_clr) ? err_code_q : ev_code;
        err_d      = err_code_d != E_NONE;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;

    // Error is a single-cycle pulse following the failing call/ret.
    always_comb begin
        err_code_d = ev_code;
        err_d      = ev_code != E_NONE;
    end
`endif

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= RST_A;
            sp_q       <= '0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
        end else begin
            addr_q     <= addr_d;
            sp_q       <= sp_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign addr        = addr_q;
    assign sp          = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign wrap        = wrap_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_program_counter_stack.sv
// tb_program_counter_stack: directed checks of counting, jump, call/ret, stack errors and reset.
module tb_program_counter_stack;
`ifdef PC_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n, count_en, jump, call, ret, err_clr;
    logic [3:0] jump_addr;
    logic [3:0] addr;
    logic [1:0] sp;
    logic       stack_full, stack_empty, wrap, err;
    logic [1:0] err_code;
    int         errors = 0;
    int         checks = 0;

    program_counter_stack #(.ADDR_W(4), .DEPTH(2), .RESET_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .count_en(count_en), .jump(jump), .call(call),
        .ret(ret), .jump_addr(jump_addr), .err_clr(err_clr), .addr(addr), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty), .wrap(wrap), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string what, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s: got %0h expected %0h", tag, what, got, exp);
        end
    endtask

    task automatic st(input string tag, input logic [3:0] a, input logic [1:0] s,
                      input logic w, input logic e, input logic [1:0] c);
        cmp(tag, "addr", {4'd0, addr}, {4'd0, a});
        cmp(tag, "sp", {6'd0, sp}, {6'd0, s});
        cmp(tag, "full", {7'd0, stack_full}, {7'd0, s == 2'd2});
        cmp(tag, "empty", {7'd0, stack_empty}, {7'd0, s == 2'd0});
        cmp(tag, "wrap", {7'd0, wrap}, {7'd0, w});
        cmp(tag, "err", {7'd0, err}, {7'd0, e});
        cmp(tag, "err_code", {6'd0, err_code}, {6'd0, c});
    endtask

    task automatic go_to(input logic [3:0] a);
        jump = 1'b1; jump_addr = a;
        tick();
        jump = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; count_en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        err_clr = 1'b0; jump_addr = 4'd0;
        tick(); tick();
        st("reset", 4'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        count_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            st($sformatf("count%0d", i), 4'(i), 2'd0, i == 16, 1'b0, 2'd0);
        end
        count_en = 1'b0;
        go_to(4'd5);
        st("jump5", 4'd5, 2'd0, 1'b0, 1'b0, 2'd0);
        call = 1'b1; jump_addr = 4'hA;
        tick(); call = 1'b0;
        st("callA", 4'hA, 2'd1, 1'b0, 1'b0, 2'd0);
        count_en = 1'b1;
        tick(); st("subB", 4'hB, 2'd1, 1'b0, 1'b0, 2'd0);
        tick(); st("subC", 4'hC, 2'd1, 1'b0, 1'b0, 2'd0);
        count_en = 1'b0; ret = 1'b1;
        tick(); ret = 1'b0;
        st("ret6", 4'd6, 2'd0, 1'b0, 1'b0, 2'd0);
        go_to(4'd1);
        call = 1'b1; jump_addr = 4'd3;
        tick(); st("call3", 4'd3, 2'd1, 1'b0, 1'b0, 2'd0);
        jump_addr = 4'd7;
        tick(); st("call7", 4'd7, 2'd2, 1'b0, 1'b0, 2'd0);
        jump_addr = 4'd9;
        tick(); call = 1'b0;
        st("ovf", 4'd7, 2'd2, 1'b0, 1'b1, 2'b01);
        tick();
        st("ovf_after", 4'd7, 2'd2, 1'b0, STICKY, STICKY ? 2'b01 : 2'b00);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        st("ovf_clr", 4'd7, 2'd2, 1'b0, 1'b0, 2'b00);
        ret = 1'b1;
        tick(); st("ret4", 4'd4, 2'd1, 1'b0, 1'b0, 2'd0);
        tick(); ret = 1'b0;
        st("ret2", 4'd2, 2'd0, 1'b0, 1'b0, 2'd0);
        go_to(4'd4);
        ret = 1'b1;
        tick(); ret = 1'b0;
        st("unf", 4'd4, 2'd0, 1'b0, 1'b1, 2'b10);
        tick();
        st("unf_after", 4'd4, 2'd0, 1'b0, STICKY, STICKY ? 2'b10 : 2'b00);
        tick();
        st("unf_hold", 4'd4, 2'd0, 1'b0, STICKY, STICKY ? 2'b10 : 2'b00);
        err_clr = 1'b1;
        tick();
        st("unf_clr", 4'd4, 2'd0, 1'b0, 1'b0, 2'b00);
        ret = 1'b1;
        tick(); ret = 1'b0; err_clr = 1'b0;
        st("clr_new", 4'd4, 2'd0, 1'b0, 1'b1, 2'b10);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        go_to(4'd2);
        count_en = 1'b1; jump = 1'b1; jump_addr = 4'd9;
        tick(); count_en = 1'b0; jump = 1'b0;
        st("jump_over_count", 4'd9, 2'd0, 1'b0, 1'b0, 2'd0);
        call = 1'b1; jump_addr = 4'd12;
        tick(); call = 1'b0;
        st("callC", 4'd12, 2'd1, 1'b0, 1'b0, 2'd0);
        call = 1'b1; ret = 1'b1; jump_addr = 4'd3;
        tick(); call = 1'b0; ret = 1'b0;
        st("ret_over_call", 4'd10, 2'd0, 1'b0, 1'b0, 2'd0);
        call = 1'b1; jump_addr = 4'd5;
        tick(); call = 1'b0;
        st("call5", 4'd5, 2'd1, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b0; call = 1'b1; jump_addr = 4'd7;
        tick(); call = 1'b0; rst_n = 1'b1;
        st("rst_mid_call", 4'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        go_to(4'd15);
        call = 1'b1; jump_addr = 4'd0;
        tick(); call = 1'b0;
        st("call_at_ff", 4'd0, 2'd1, 1'b0, 1'b0, 2'd0);
        ret = 1'b1;
        tick(); ret = 1'b0;
        st("ret_to_0", 4'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
